// File: rtl/pipe_scroller_if.sv
//------------------------------------------------------------------------------
// pipe_scroller_if : game-tick/control inputs and pipe/score outputs of the
//                    Flappy Bird pipe scroller.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_scroller_if;
  logic       tick;
  logic       start;
  logic       freeze;
  logic [9:0] pipe_x;
  logic [9:0] gap_y;
  logic [7:0] score_bcd;
  logic       pass_pulse;
  logic       running;

  modport master (
    output tick, start, freeze,
    input  pipe_x, gap_y, score_bcd, pass_pulse, running
  );

  modport slave (
    input  tick, start, freeze,
    output pipe_x, gap_y, score_bcd, pass_pulse, running
  );
endinterface

`default_nettype wire

// File: rtl/pipe_scroller.sv
//------------------------------------------------------------------------------
// pipe_scroller : scrolling pipe obstacle, LFSR gap placement, BCD score and
//                 IDLE/RUN/FROZEN game-phase state machine.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_scroller #(
  parameter int unsigned   SCREEN_W  = 640,
  parameter int unsigned   PIPE_W    = 50,
  parameter int unsigned   STEP      = 2,
  parameter int unsigned   BIRD_X    = 100,
  parameter int unsigned   GAP_MIN   = 40,
  parameter int unsigned   GAP_RANGE = 301,
  parameter logic [15:0]   LFSR_SEED = 16'hACE1
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pipe_scroller_if.slave    bus
);

  localparam logic [9:0]  c_screen_w  = 10'(SCREEN_W);
  localparam logic [9:0]  c_step      = 10'(STEP);
  localparam logic [10:0] c_pipe_w    = 11'(PIPE_W);
  localparam logic [10:0] c_bird_x    = 11'(BIRD_X);
  localparam logic [9:0]  c_gap_min   = 10'(GAP_MIN);
  localparam logic [9:0]  c_gap_range = 10'(GAP_RANGE);
  localparam logic [7:0]  c_score_max = 8'h99;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  pipe_x_q, pipe_x_d;
  logic [9:0]  gap_y_q, gap_y_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  score_q, score_d;
  logic        pass_q, pass_d;
  logic        running_q, running_d;

  logic [15:0] lfsr_next;
  logic        respawn;
  logic [9:0]  new_x;
  logic        pass_evt;

  // Low 9 LFSR bits folded into the legal range with one conditional subtract.
  function automatic logic [9:0] gap_of(input logic [8:0] v);
    logic [9:0] c;
    logic [9:0] m;
    c = {1'b0, v};
    if (c < c_gap_range) m = c;
    else                 m = c - c_gap_range;
    return m + c_gap_min;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == c_score_max)      r = s;
    else if (s[3:0] == 4'd9)   r = {s[7:4] + 4'd1, 4'd0};
    else                       r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign respawn   = (pipe_x_q < c_step);
  assign new_x     = respawn ? c_screen_w : (pipe_x_q - c_step);
  assign pass_evt  = (({1'b0, pipe_x_q} + c_pipe_w) >= c_bird_x) &&
                     (({1'b0, new_x}    + c_pipe_w) <  c_bird_x);

  always_comb begin
    state_d  = state_q;
    pipe_x_d = pipe_x_q;
    gap_y_d  = gap_y_q;
    lfsr_d   = lfsr_q;
    score_d  = score_q;
    pass_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        pipe_x_d = c_screen_w;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        // Collision wins over a coincident tick so the final frame stays put.
        if (bus.freeze) begin
          state_d = S_FROZEN;
        end else if (bus.tick) begin
          pipe_x_d = new_x;
          if (respawn) begin
            lfsr_d  = lfsr_next;
            gap_y_d = gap_of(lfsr_next[8:0]);
          end
          if (pass_evt) begin
            pass_d  = 1'b1;
            score_d = bcd_inc(score_q);
          end
        end
      end
      S_FROZEN: begin
        if (bus.start) begin
          state_d  = S_IDLE;
          pipe_x_d = c_screen_w;
          score_d  = 8'h00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pipe_x_q  <= c_screen_w;
      lfsr_q    <= LFSR_SEED;
      gap_y_q   <= gap_of(LFSR_SEED[8:0]);
      score_q   <= 8'h00;
      pass_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pipe_x_q  <= pipe_x_d;
      lfsr_q    <= lfsr_d;
      gap_y_q   <= gap_y_d;
      score_q   <= score_d;
      pass_q    <= pass_d;
      running_q <= running_d;
    end
  end

  assign bus.pipe_x     = pipe_x_q;
  assign bus.gap_y      = gap_y_q;
  assign bus.score_bcd  = score_q;
  assign bus.pass_pulse = pass_q;
  assign bus.running    = running_q;

endmodule

`default_nettype wire

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Generates the scrolling pipe obstacle and the game score for the Flappy Bird datapath.
- Runs on the system clock and advances one step per game-tick strobe.
- Feeds pipe_x/gap_y to the per-pixel colour and collision generator, and score_bcd to the HEX display driver.
- Consumes the collision flag (freeze) and the player start button; owns the IDLE/RUN/FROZEN game-phase state machine.

Parameters:
- SCREEN_W, 640, pipe spawn column (left edge value on respawn/park)
- PIPE_W, 50, pipe width in pixels
- STEP, 2, pixels moved left per tick
- BIRD_X, 100, bird column used for pass/score detection
- GAP_MIN, 40, smallest gap_y
- GAP_RANGE, 301, number of legal gap_y values (gap_y in GAP_MIN..GAP_MIN+GAP_RANGE-1)
- LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle game-tick strobe (synchronous to clk)
- start  in  1  start/restart request, level, sampled each clk
- freeze  in  1  collision detected, level
- pipe_x  out  10  pipe left-edge column
- gap_y  out  10  top row of the pipe gap (gap height fixed downstream at 100)
- score_bcd  out  8  two BCD digits [7:4] tens, [3:0] units
- pass_pulse  out  1  one-cycle strobe when the bird clears a pipe
- running  out  1  high while in RUN

Behaviour:
- Reset (async, immediate), with all outputs registered:
  - state=IDLE; pipe_x=SCREEN_W; lfsr=LFSR_SEED; gap_y=GAP_MIN+map(LFSR_SEED) (=265 with defaults).
  - score_bcd=8'h00; pass_pulse=0; running=0.
- map(v): c=v[8:0]; result = c if c<GAP_RANGE, else c-GAP_RANGE. A single subtraction; no divider.
- LFSR: 16-bit Fibonacci, shift left, new bit[0] = l[15]^l[13]^l[12]^l[10]. Advances only on respawn.
- IDLE:
  - pipe parked at SCREEN_W; ticks ignored.
  - start=1 → RUN next cycle.
- RUN, on a tick with freeze=0:
  - If pipe_x < STEP: respawn. pipe_x<=SCREEN_W; lfsr<=lfsr_next; gap_y<=GAP_MIN+map(lfsr_next).
  - Else: pipe_x<=pipe_x-STEP.
  - Pass event: old pipe_x+PIPE_W >= BIRD_X and new pipe_x+PIPE_W < BIRD_X.
    - pass_pulse=1 for exactly the cycle after the tick.
    - score_bcd increments in BCD (09→10); saturates at 99 (pulse still fires).
- RUN, freeze=1 → FROZEN next cycle. freeze has priority over a same-cycle tick: no move, no score.
- No tick: all outputs hold; pass_pulse=0.
- FROZEN:
  - Pipe, gap and score hold (the final picture remains displayable); ticks ignored.
  - start=1 → IDLE: pipe_x<=SCREEN_W; score_bcd<=0; gap_y keeps its current value; LFSR is not reseeded.
- start in RUN is ignored. freeze in IDLE/FROZEN is ignored.
- running = (state==RUN), registered.
- Width rules: the pipe_x+PIPE_W comparison uses 11 bits, so there is no wrap. pipe_x never underflows because of the respawn rule.

Test Plan:
- Reset mid-RUN (pipe_x=300) → all outputs immediately return to pipe_x=640, gap_y=265, score=00, running=0.
- Reset, start, 1 tick → running=1, pipe_x=638; further ticks without start in IDLE beforehand → no movement.
- RUN, 296 ticks → pipe_x=48, pass_pulse high for one cycle, score_bcd=8'h01. 320 ticks → pipe_x=0. Tick 321 → pipe_x=640, gap_y=190, lfsr=16'h59C3.
- freeze and tick in the same cycle at pipe_x=500 → FROZEN, pipe_x stays 500. Further ticks → no change. start → IDLE, pipe_x=640, score=00, gap_y unchanged.
- Force score to 09, pass → 8'h10. Score at 99, pass → stays 8'h99 and pass_pulse=1.
- Random tick spacing over 10 respawns → gap_y always within 40..340; pipe_x always in 0..640 and even.
